// File: rtl/clk_reset_gen.sv
// Per-channel mclk divider (50% duty, glitch-free ratio change) with staggered, clock-aligned reset release.
// Optional CLK_RESET_GEN_STOP_EN adds ch_stop to park individual divided clocks low.
module clk_reset_gen #(
  parameter int NCH         = 3,
  parameter int DIVW        = 8,
  parameter int DIV_DEFAULT = 0,
  parameter int RST_HOLD    = 16,
  parameter int STAGGER     = 4
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic [NCH*DIVW-1:0] div_cfg,
  input  logic                div_load,
  input  logic [NCH-1:0]      ch_soft_rst,
`ifdef CLK_RESET_GEN_STOP_EN
  input  logic [NCH-1:0]      ch_stop,
`endif
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      clk_en,
  output logic [NCH-1:0]      rst_n_out,
  output logic                ready
);

  localparam int CMAX = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DIVW-1:0] DEF_DIV = DIVW'(DIV_DEFAULT);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_STAGGER, S_RUN} state_t;

  logic [DIVW-1:0] cnt    [NCH];
  logic [DIVW-1:0] act    [NCH];
  logic [DIVW-1:0] shadow [NCH];
  logic [NCH-1:0]  run;
  logic [NCH-1:0]  at_end;
  logic [NCH-1:0]  rise;

  // rise is the cycle a divided clock goes 0->1; it also marks the period boundary.
  always_comb begin
    run    = '1;
    at_end = '0;
    rise   = '0;
    for (int i = 0; i < NCH; i++) begin
      at_end[i] = (cnt[i] == act[i]);
`ifdef CLK_RESET_GEN_STOP_EN
      run[i] = ~(ch_stop[i] & ~clk_out[i]);
`endif
      rise[i] = run[i] & at_end[i] & ~clk_out[i];
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        act[i]    <= DEF_DIV;
        shadow[i] <= DEF_DIV;
      end
      clk_out <= '0;
      clk_en  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!run[i]) begin
          cnt[i] <= '0;
        end else if (at_end[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
        end else begin
          cnt[i] <= cnt[i] + DIVW'(1);
        end
        if (rise[i]) act[i] <= shadow[i];
        if (div_load) shadow[i] <= div_cfg[i*DIVW +: DIVW];
      end
      clk_en <= rise;
    end
  end

  state_t          state, state_d;
  logic [CW-1:0]   tcnt, tcnt_d;
  logic [IW-1:0]   idx, idx_d;
  logic [NCH-1:0]  rel_set;

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state <= S_HOLD;
      tcnt  <= '0;
      idx   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      tcnt  <= tcnt_d;
      idx   <= idx_d;
      ready <= (state == S_RUN);
    end
  end

  always_comb begin
    state_d = state;
    tcnt_d  = tcnt;
    idx_d   = idx;
    rel_set = '0;
    case (state)
      S_HOLD: begin
        if (tcnt == CW'(RST_HOLD - 1)) begin
          state_d = S_RELEASE;
          tcnt_d  = '0;
          idx_d   = '0;
        end else begin
          tcnt_d = tcnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (rise[idx]) begin
          rel_set[idx] = 1'b1;
          if (idx == IW'(NCH - 1)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_STAGGER;
            tcnt_d  = '0;
          end
        end
      end
      S_STAGGER: begin
        if (tcnt == CW'(STAGGER - 1)) begin
          state_d = S_RELEASE;
          tcnt_d  = '0;
          idx_d   = idx + IW'(1);
        end else begin
          tcnt_d = tcnt + CW'(1);
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_HOLD;
    endcase
  end

  // Soft-reset release passes two channel-clock sync stages (advanced only on rise).
  logic [NCH-1:0] seq_rel, seq_rel_d;
  logic [NCH-1:0] sync1, sync1_d;
  logic [NCH-1:0] sync2, sync2_d;

  always_comb begin
    seq_rel_d = seq_rel | rel_set;
    sync1_d   = sync1;
    sync2_d   = sync2;
    for (int i = 0; i < NCH; i++) begin
      if (ch_soft_rst[i]) begin
        sync1_d[i] = 1'b0;
        sync2_d[i] = 1'b0;
      end else if (rise[i]) begin
        sync1_d[i] = 1'b1;
        sync2_d[i] = sync1[i];
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      seq_rel   <= '0;
      sync1     <= '1;
      sync2     <= '1;
      rst_n_out <= '0;
    end else begin
      seq_rel   <= seq_rel_d;
      sync1     <= sync1_d;
      sync2     <= sync2_d;
      rst_n_out <= seq_rel_d & sync2_d;
    end
  end

endmodule

// File: tb/tb_clk_reset_gen.sv
// Bench for clk_reset_gen: period/boundary-arithmetic reference model checked every mclk cycle.
module tb_clk_reset_gen;
  localparam int NCH = 3, DIVW = 8, DIV_DEFAULT = 0, RST_HOLD = 16, STAGGER = 4;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic                reset_n;
  logic [NCH*DIVW-1:0] div_cfg;
  logic                div_load;
  logic [NCH-1:0]      ch_soft_rst;
  logic [NCH-1:0]      clk_out, clk_en, rst_n_out;
  logic                ready;
`ifdef CLK_RESET_GEN_STOP_EN
  logic [NCH-1:0]      ch_stop = '0;
`endif

  clk_reset_gen #(.NCH(NCH), .DIVW(DIVW), .DIV_DEFAULT(DIV_DEFAULT),
                  .RST_HOLD(RST_HOLD), .STAGGER(STAGGER)) dut (
    .mclk(mclk), .reset_n(reset_n), .div_cfg(div_cfg), .div_load(div_load),
    .ch_soft_rst(ch_soft_rst),
`ifdef CLK_RESET_GEN_STOP_EN
    .ch_stop(ch_stop),
`endif
    .clk_out(clk_out), .clk_en(clk_en), .rst_n_out(rst_n_out), .ready(ready));

  int checks = 0, failures = 0;

  // Reference model: n = posedges since reset_n went high; rising edges tracked as absolute times.
  int n;
  int next_rise [NCH];
  int last_rise [NCH];
  int cur_d     [NCH];
  int shadow_m  [NCH];
  int soft_cnt  [NCH];
  bit seen      [NCH];
  bit seq_rel_m [NCH];
  int pend, earliest, rlast;
  logic [NCH-1:0] rise_m;

  task automatic check_vec(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task model_reset();
    n = 0; pend = 0; earliest = RST_HOLD + 1; rlast = 0;
    for (int i = 0; i < NCH; i++) begin
      next_rise[i] = DIV_DEFAULT + 1; last_rise[i] = 0; cur_d[i] = DIV_DEFAULT;
      shadow_m[i] = DIV_DEFAULT; soft_cnt[i] = 2; seen[i] = 0; seq_rel_m[i] = 0;
    end
  endtask

  task tick();
    logic [NCH-1:0] e_clk, e_en, e_rst;
    logic [0:0]     e_rdy;
    @(posedge mclk);
    if (!reset_n) begin
      model_reset();
    end else begin
      n++;
      for (int i = 0; i < NCH; i++) begin
        rise_m[i] = (n == next_rise[i]);
        if (rise_m[i]) begin
          cur_d[i] = shadow_m[i]; last_rise[i] = n; seen[i] = 1;
          next_rise[i] = n + 2 * (cur_d[i] + 1);
        end
      end
      if (pend < NCH && n >= earliest && rise_m[pend]) begin
        seq_rel_m[pend] = 1; earliest = n + STAGGER + 1;
        if (pend == NCH - 1) rlast = n;
        pend++;
      end
      for (int i = 0; i < NCH; i++) begin
        if (ch_soft_rst[i]) soft_cnt[i] = 0;
        else if (rise_m[i] && soft_cnt[i] < 2) soft_cnt[i]++;
        if (div_load) shadow_m[i] = int'(div_cfg[i*DIVW +: DIVW]);
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i] = seen[i] && ((n - last_rise[i]) < cur_d[i] + 1);
      e_en[i]  = seen[i] && (n == last_rise[i]);
      e_rst[i] = seq_rel_m[i] && (soft_cnt[i] == 2);
    end
    e_rdy = (pend == NCH && n > rlast) ? 1'b1 : 1'b0;
    check_vec("clk_out", clk_out, e_clk);
    check_vec("clk_en", clk_en, e_en);
    check_vec("rst_n_out", rst_n_out, e_rst);
    check_vec("ready", {{(NCH-1){1'b0}}, ready}, {{(NCH-1){1'b0}}, e_rdy});
  endtask

  task rand_cfg(input int maxd);
    for (int c = 0; c < NCH; c++) div_cfg[c*DIVW +: DIVW] = DIVW'($urandom_range(0, maxd));
  endtask

  initial begin
    reset_n = 1'b0; div_cfg = '0; div_load = 1'b0; ch_soft_rst = '0;
    model_reset();
    // Power-on: reset state, then default /2 and the staggered release
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (60) tick();
    check_vec("t1_ready", {{(NCH-1){1'b0}}, ready}, {{(NCH-1){1'b0}}, 1'b1});
    check_vec("t1_rst_all", rst_n_out, {NCH{1'b1}});

    // Ratio change on ch0 only
    div_cfg = '0; div_cfg[0 +: DIVW] = 8'd3; div_load = 1'b1; tick(); div_load = 1'b0;
    repeat (40) tick();

    // Soft reset on ch1 for three cycles in the run state
    ch_soft_rst = 3'b010; repeat (3) tick(); ch_soft_rst = '0;
    repeat (24) tick();

    // Random ratios, back-to-back loads and soft-reset pulses
    for (int r = 0; r < 12; r++) begin
      rand_cfg(6); div_load = 1'b1; tick(); div_load = 1'b0;
      ch_soft_rst = NCH'($urandom_range(0, (1 << NCH) - 1));
      repeat ($urandom_range(1, 4)) tick();
      ch_soft_rst = '0;
      if ($urandom_range(0, 1) == 1) begin
        rand_cfg(6); div_load = 1'b1; tick();
        rand_cfg(6); tick(); div_load = 1'b0;
      end
      repeat ($urandom_range(10, 40)) tick();
    end

    // Maximum divide field on ch2
    div_cfg = {8'd255, 8'd1, 8'd2}; div_load = 1'b1; tick(); div_load = 1'b0;
    repeat (1300) tick();

    // Reset restart, then a one-cycle reset mid-release with a load that must be ignored
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    repeat (20) tick();
    reset_n = 1'b0; div_cfg = {8'd5, 8'd5, 8'd5}; div_load = 1'b1; tick();
    reset_n = 1'b1; div_load = 1'b0;
    check_vec("t5_rst_low", rst_n_out, '0);
    repeat (60) tick();

    // Random ratios plus soft resets while the sequencer is still releasing
    for (int r = 0; r < 4; r++) begin
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      rand_cfg(5); div_load = 1'b1; tick(); div_load = 1'b0;
      repeat ($urandom_range(5, 25)) tick();
      ch_soft_rst = NCH'($urandom_range(1, (1 << NCH) - 1));
      repeat ($urandom_range(1, 6)) tick();
      ch_soft_rst = '0;
      repeat (90) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
